// File: rtl/dp_ram_be.sv
// Simple-dual-port RAM with a byte-enabled read/write port A, a read-only port B, and a sequencer that clears the array.
// Optional build macro: DP_RAM_BE_OUTREG_EN adds an output register stage, which makes the read latency 2.
module dp_ram_be #(
  parameter int              DATA     = 8,
  parameter int              ADDR     = 10,
  parameter int              RDW_MODE = 0,
  parameter logic [DATA-1:0] INIT_VAL = {DATA{1'b0}}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_req,
  output logic                    clr_busy,
  input  logic                    a_wr,
  input  logic [(DATA+7)/8-1:0]   a_be,
  input  logic [ADDR-1:0]         a_addr,
  input  logic [DATA-1:0]         a_din,
  output logic [DATA-1:0]         a_dout,
  input  logic [ADDR-1:0]         b_addr,
  output logic [DATA-1:0]         b_dout
);

  localparam int NBE   = (DATA + 7) / 8;
  localparam int DEPTH = 2 ** ADDR;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  // Expand the byte enables to a per-bit mask. A partial top lane only covers the bits that exist.
  function automatic logic [DATA-1:0] lane_mask(input logic [NBE-1:0] be);
    logic [DATA-1:0] m;
    m = {DATA{1'b0}};
    for (int j = 0; j < DATA; j++) begin
      m[j] = be[j >> 3];
    end
    return m;
  endfunction

  // Merge new data into the old word, using the mask to select the bits that change.
  function automatic logic [DATA-1:0] merge_word(input logic [DATA-1:0] old_w,
                                                 input logic [DATA-1:0] new_w,
                                                 input logic [DATA-1:0] mask);
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  logic [DATA-1:0] mem_r [0:DEPTH-1];

  state_t          state_r;
  state_t          state_next_s;
  logic [ADDR-1:0] cnt_r;
  logic            clr_busy_r;

  logic            wr_en_s;
  logic [ADDR-1:0] wr_addr_s;
  logic [DATA-1:0] wr_data_s;
  logic [DATA-1:0] wr_mask_s;
  logic [DATA-1:0] wr_word_s;

  logic [DATA-1:0] a_mask_s;
  logic [DATA-1:0] a_old_s;
  logic [DATA-1:0] b_old_s;
  logic [DATA-1:0] a_rd_s;
  logic [DATA-1:0] b_rd_s;
  logic [DATA-1:0] a_q1_r;
  logic [DATA-1:0] b_q1_r;

  // State register. Reset always re-enters CLEAR, so the array is rewritten from word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_CLEAR;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic. A clear request is only accepted in IDLE; CLEAR always runs to the last word.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (clr_req) begin
          state_next_s = S_CLEAR;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (cnt_r == {ADDR{1'b1}}) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_CLEAR;
        end
      end
      default: state_next_s = S_CLEAR;
    endcase
  end

  // Clear address counter and the registered busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= {ADDR{1'b0}};
      clr_busy_r <= 1'b1;
    end else begin
      clr_busy_r <= (state_next_s == S_CLEAR);
      if (state_r == S_CLEAR) begin
        cnt_r <= cnt_r + ADDR'(1);
      end else if (clr_req) begin
        cnt_r <= {ADDR{1'b0}};
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign clr_busy = clr_busy_r;
  assign a_mask_s = lane_mask(a_be);

  // Single write port, shared between the clear sequencer and port A. Port A writes are dropped while the array is clearing.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = a_addr;
    wr_data_s = a_din;
    wr_mask_s = a_mask_s;
    if (state_r == S_CLEAR) begin
      wr_en_s   = 1'b1;
      wr_addr_s = cnt_r;
      wr_data_s = INIT_VAL;
      wr_mask_s = {DATA{1'b1}};
    end else begin
      wr_en_s   = a_wr;
    end
  end

  assign wr_word_s = merge_word(mem_r[wr_addr_s], wr_data_s, wr_mask_s);

  // Array storage. There is deliberately no reset; the clear sequencer initialises the contents.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= wr_word_s;
    end
  end

  assign a_old_s = mem_r[a_addr];
  assign b_old_s = mem_r[b_addr];

  // Read-during-write selection for both ports. A port A write always collides with a port A read.
  always_comb begin
    a_rd_s = a_old_s;
    b_rd_s = b_old_s;
    if ((RDW_MODE != 0) && a_wr && (state_r == S_IDLE)) begin
      a_rd_s = merge_word(a_old_s, a_din, a_mask_s);
      if (b_addr == a_addr) begin
        b_rd_s = merge_word(b_old_s, a_din, a_mask_s);
      end else begin
        b_rd_s = b_old_s;
      end
    end else begin
      a_rd_s = a_old_s;
      b_rd_s = b_old_s;
    end
  end

  // First read stage. Both ports show INIT_VAL while the array is clearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q1_r <= {DATA{1'b0}};
      b_q1_r <= {DATA{1'b0}};
    end else if (state_r == S_CLEAR) begin
      a_q1_r <= INIT_VAL;
      b_q1_r <= INIT_VAL;
    end else begin
      a_q1_r <= a_rd_s;
      b_q1_r <= b_rd_s;
    end
  end

`ifdef DP_RAM_BE_OUTREG_EN
  logic [DATA-1:0] a_q2_r;
  logic [DATA-1:0] b_q2_r;

  // Optional second output stage. It also loads INIT_VAL during a clear, so the outputs settle one cycle earlier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q2_r <= {DATA{1'b0}};
      b_q2_r <= {DATA{1'b0}};
    end else if (state_r == S_CLEAR) begin
      a_q2_r <= INIT_VAL;
      b_q2_r <= INIT_VAL;
    end else begin
      a_q2_r <= a_q1_r;
      b_q2_r <= b_q1_r;
    end
  end

  assign a_dout = a_q2_r;
  assign b_dout = b_q2_r;
`else
  assign a_dout = a_q1_r;
  assign b_dout = b_q1_r;
`endif

endmodule
